// File: rtl/cpu_hazard_pkg.sv
// Shared types and constants for the pipeline hazard control block.
package cpu_hazard_pkg;

  localparam int unsigned REG_ADDR_W_DEFAULT = 5;
  localparam int unsigned PERF_CNT_W         = 32;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/cpu_hazard_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline, slave is the hazard unit.
interface cpu_hazard_if #(
  parameter int unsigned REG_ADDR_W = cpu_hazard_pkg::REG_ADDR_W_DEFAULT
);

  logic [REG_ADDR_W-1:0] ra_id;
  logic [REG_ADDR_W-1:0] rb_id;
  logic                  ra_used_id;
  logic                  rb_used_id;
  logic [REG_ADDR_W-1:0] rd_ex;
  logic                  memread_ex;
  logic                  branch_taken_ex;
  logic                  dmem_req_mem;
  logic                  dmem_ready_mem;

  logic                  stall_if;
  logic                  stall_id;
  logic                  bubble_ex;
  logic                  flush_if_id;
  logic                  freeze_pipe;
  logic                  mem_timeout;
  logic [1:0]            hazard_state;
  logic [cpu_hazard_pkg::PERF_CNT_W-1:0] stall_cycles;
  logic [cpu_hazard_pkg::PERF_CNT_W-1:0] flush_count;

  modport master (
    output ra_id, rb_id, ra_used_id, rb_used_id, rd_ex, memread_ex,
           branch_taken_ex, dmem_req_mem, dmem_ready_mem,
    input  stall_if, stall_id, bubble_ex, flush_if_id, freeze_pipe,
           mem_timeout, hazard_state, stall_cycles, flush_count
  );

  modport slave (
    input  ra_id, rb_id, ra_used_id, rb_used_id, rd_ex, memread_ex,
           branch_taken_ex, dmem_req_mem, dmem_ready_mem,
    output stall_if, stall_id, bubble_ex, flush_if_id, freeze_pipe,
           mem_timeout, hazard_state, stall_cycles, flush_count
  );

endinterface

// File: rtl/cpu_hazard_perf_counters.sv
// Stall-cycle and flush-cycle performance counters; wrap modulo 2^PERF_CNT_W.
module cpu_hazard_perf_counters
  import cpu_hazard_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] flush_count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + 1'b1;
      if (flush) flush_count  <= flush_count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_hazard_unit.sv
// Hazard control for the 5-stage core: load-use stalls, branch flush, data-memory freeze
// with sticky timeout. Define CPU_HAZARD_PERF_EN to build the performance counters.
module cpu_hazard_unit
  import cpu_hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W       = REG_ADDR_W_DEFAULT,
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT      = 256
) (
  input logic         clock,
  input logic         reset,
  cpu_hazard_if.slave hz
);

  localparam int unsigned       TCNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(MEM_TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [1:0]        BCNT_INIT = 2'(LOAD_USE_BUBBLES - 1);

  hazard_state_t         state, state_nxt, ret, ret_nxt, eval_state;
  logic [1:0]            bcnt, bcnt_nxt;
  logic [TCNT_W-1:0]     tcnt;
  logic                  timeout_flag;
  logic                  mem_wait, load_use;
  logic                  stall, bubble, flush, freeze;
  logic [REG_ADDR_W-1:0] ra, rb, rd;
  logic [PERF_CNT_W-1:0] stall_cnt, flush_cnt;

  assign ra = hz.ra_id;
  assign rb = hz.rb_id;
  assign rd = hz.rd_ex;

  assign mem_wait = hz.dmem_req_mem & ~hz.dmem_ready_mem;
  assign load_use = hz.memread_ex & (rd != '0) &
                    ((hz.ra_used_id & (ra == rd)) | (hz.rb_used_id & (rb == rd)));

  // The first cycle out of MEM_WAIT is evaluated as the saved state, so work held during the freeze proceeds at once.
  assign eval_state = (state == MEM_WAIT) ? ret : state;

  always_comb begin
    stall     = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    freeze    = 1'b0;
    state_nxt = state;
    ret_nxt   = ret;
    bcnt_nxt  = bcnt;
    if (mem_wait) begin
      freeze = 1'b1;
      stall  = 1'b1;
      if (state != MEM_WAIT) begin
        ret_nxt   = state;
        state_nxt = MEM_WAIT;
      end
    end else begin
      case (eval_state)
        LOAD_STALL: begin
          stall     = 1'b1;
          bubble    = 1'b1;
          bcnt_nxt  = bcnt - 1'b1;
          state_nxt = (bcnt == 2'd1) ? RUN : LOAD_STALL;
        end
        default: begin
          state_nxt = RUN;
          if (hz.branch_taken_ex) begin
            flush  = 1'b1;
            bubble = 1'b1;
          end else if (load_use) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (LOAD_USE_BUBBLES > 1) begin
              state_nxt = LOAD_STALL;
              bcnt_nxt  = BCNT_INIT;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RUN;
      ret          <= RUN;
      bcnt         <= '0;
      tcnt         <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      ret   <= ret_nxt;
      bcnt  <= bcnt_nxt;
      if (mem_wait) begin
        if (tcnt != TCNT_MAX) tcnt <= tcnt + 1'b1;
        if (tcnt >= TCNT_LAST) timeout_flag <= 1'b1;
      end else begin
        tcnt <= '0;
      end
    end
  end

`ifdef CPU_HAZARD_PERF_EN
  cpu_hazard_perf_counters u_perf (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall & ~reset),
    .flush        (flush & ~reset),
    .stall_cycles (stall_cnt),
    .flush_count  (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  assign hz.stall_if     = stall & ~reset;
  assign hz.stall_id     = stall & ~reset;
  assign hz.bubble_ex    = bubble & ~reset;
  assign hz.flush_if_id  = flush & ~reset;
  assign hz.freeze_pipe  = freeze & ~reset;
  assign hz.mem_timeout  = timeout_flag & ~reset;
  assign hz.hazard_state = reset ? RUN : state;
  assign hz.stall_cycles = reset ? '0 : stall_cnt;
  assign hz.flush_count  = reset ? '0 : flush_cnt;

endmodule

// File: tb/tb_cpu_hazard_unit.sv
// Directed bench: u1 (1 bubble, timeout 8) and u3 (3 bubbles, timeout 256) share clock and reset.
module tb_cpu_hazard_unit;
  import cpu_hazard_pkg::*;

`ifdef CPU_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  cpu_hazard_if #(.REG_ADDR_W(5)) if1 ();
  cpu_hazard_if #(.REG_ADDR_W(5)) if3 ();

  cpu_hazard_unit #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(8)) u1 (
    .clock (clock),
    .reset (reset),
    .hz    (if1)
  );

  cpu_hazard_unit #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(256)) u3 (
    .clock (clock),
    .reset (reset),
    .hz    (if3)
  );

  // {stall_if, stall_id, bubble_ex, flush_if_id, freeze_pipe}
  logic [4:0] ctl1, ctl3;
  assign ctl1 = {if1.stall_if, if1.stall_id, if1.bubble_ex, if1.flush_if_id, if1.freeze_pipe};
  assign ctl3 = {if3.stall_if, if3.stall_id, if3.bubble_ex, if3.flush_if_id, if3.freeze_pipe};

  // EX holds a bubble during LOAD_STALL, so a taken branch there is a stimulus error.
  always @(negedge clock) begin
    if (!reset && ((if1.hazard_state == 2'd1 && if1.branch_taken_ex) ||
                   (if3.hazard_state == 2'd1 && if3.branch_taken_ex))) begin
      n_bad++;
      $display("FAIL branch_in_load_stall: branch_taken_ex=1 observed while hazard_state=1, required never");
    end
  end

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic drv1(input logic mr, input logic [4:0] rd, input logic [4:0] ra, input logic rau,
                      input logic [4:0] rb, input logic rbu, input logic br, input logic req,
                      input logic rdy);
    if1.memread_ex      = mr;
    if1.rd_ex           = rd;
    if1.ra_id           = ra;
    if1.ra_used_id      = rau;
    if1.rb_id           = rb;
    if1.rb_used_id      = rbu;
    if1.branch_taken_ex = br;
    if1.dmem_req_mem    = req;
    if1.dmem_ready_mem  = rdy;
  endtask

  task automatic drv3(input logic mr, input logic [4:0] rd, input logic [4:0] ra, input logic rau,
                      input logic [4:0] rb, input logic rbu, input logic br, input logic req,
                      input logic rdy);
    if3.memread_ex      = mr;
    if3.rd_ex           = rd;
    if3.ra_id           = ra;
    if3.ra_used_id      = rau;
    if3.rb_id           = rb;
    if3.rb_used_id      = rbu;
    if3.branch_taken_ex = br;
    if3.dmem_req_mem    = req;
    if3.dmem_ready_mem  = rdy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv1(1, 5, 5, 1, 0, 0, 1, 1, 0);
    drv3(1, 5, 0, 0, 5, 1, 0, 1, 0);
    settle();
    n_cmp++; if (ctl1 !== 5'b00000) begin n_bad++; $display("FAIL rst_ctl1: got %b want %b", ctl1, 5'b00000); end
    n_cmp++; if (ctl3 !== 5'b00000) begin n_bad++; $display("FAIL rst_ctl3: got %b want %b", ctl3, 5'b00000); end
    n_cmp++; if (if1.mem_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b want 0", if1.mem_timeout); end
    n_cmp++; if (if1.stall_cycles !== 32'd0) begin n_bad++; $display("FAIL rst_stall_cnt: got %0d want 0", if1.stall_cycles); end
    adv();
    reset = 1'b0;
    drv1(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drv3(0, 0, 0, 0, 0, 0, 0, 0, 1);
    settle();
    n_cmp++; if (ctl1 !== 5'b00000) begin n_bad++; $display("FAIL post_rst_ctl: got %b want %b", ctl1, 5'b00000); end
    n_cmp++; if (if3.hazard_state !== 2'd0) begin n_bad++; $display("FAIL post_rst_state: got %0d want 0", if3.hazard_state); end
    adv();
  endtask

  task automatic test_load_use_single();
    drv1(1, 5, 5, 1, 0, 0, 0, 0, 1);
    settle();
    n_cmp++; if (ctl1 !== 5'b11100) begin n_bad++; $display("FAIL lu_ra_stall: got %b want %b", ctl1, 5'b11100); end
    n_cmp++; if (if1.hazard_state !== 2'd0) begin n_bad++; $display("FAIL lu_ra_state: got %0d want 0", if1.hazard_state); end
    adv();
    drv1(0, 0, 0, 0, 0, 0, 0, 0, 1);
    settle();
    n_cmp++; if (ctl1 !== 5'b00000) begin n_bad++; $display("FAIL lu_ra_after: got %b want %b", ctl1, 5'b00000); end
    adv();
    drv1(1, 0, 0, 1, 0, 0, 0, 0, 1);
    settle();
    n_cmp++; if (ctl1 !== 5'b00000) begin n_bad++; $display("FAIL lu_rd_zero: got %b want %b", ctl1, 5'b00000); end
    adv();
    drv1(1, 5, 5, 0, 0, 0, 0, 0, 1);
    settle();
    n_cmp++; if (ctl1 !== 5'b00000) begin n_bad++; $display("FAIL lu_ra_unused: got %b want %b", ctl1, 5'b00000); end
    adv();
    drv1(1, 9, 0, 0, 9, 1, 0, 0, 1);
    settle();
    n_cmp++; if (ctl1 !== 5'b11100) begin n_bad++; $display("FAIL lu_rb_stall: got %b want %b", ctl1, 5'b11100); end
    adv();
    drv1(0, 5, 5, 1, 0, 0, 0, 0, 1);
    settle();
    n_cmp++; if (ctl1 !== 5'b00000) begin n_bad++; $display("FAIL lu_not_load: got %b want %b", ctl1, 5'b00000); end
    adv();
    drv1(1, 5, 6, 1, 4, 1, 0, 0, 1);
    settle();
    n_cmp++; if (ctl1 !== 5'b00000) begin n_bad++; $display("FAIL lu_no_match: got %b want %b", ctl1, 5'b00000); end
    adv();
    drv1(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_load_use_multi();
    logic [4:0] ec [4] = '{5'b11100, 5'b11100, 5'b11100, 5'b00000};
    logic [1:0] es [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
    drv3(1, 7, 3, 1, 7, 1, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      settle();
      n_cmp++; if (ctl3 !== ec[k]) begin n_bad++; $display("FAIL lu3_ctl[%0d]: got %b want %b", k, ctl3, ec[k]); end
      n_cmp++; if (if3.hazard_state !== es[k]) begin n_bad++; $display("FAIL lu3_state[%0d]: got %0d want %0d", k, if3.hazard_state, es[k]); end
      adv();
      drv3(0, 0, 0, 0, 0, 0, 0, 0, 1);
    end
  endtask

  task automatic test_branch_priority();
    drv1(1, 5, 5, 1, 0, 0, 1, 0, 1);
    drv3(1, 5, 5, 1, 0, 0, 1, 0, 1);
    settle();
    n_cmp++; if (ctl1 !== 5'b00110) begin n_bad++; $display("FAIL br_lu_ctl1: got %b want %b", ctl1, 5'b00110); end
    n_cmp++; if (ctl3 !== 5'b00110) begin n_bad++; $display("FAIL br_lu_ctl3: got %b want %b", ctl3, 5'b00110); end
    adv();
    drv1(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drv3(0, 0, 0, 0, 0, 0, 0, 0, 1);
    settle();
    n_cmp++; if (if3.hazard_state !== 2'd0) begin n_bad++; $display("FAIL br_lu_state: got %0d want 0", if3.hazard_state); end
    n_cmp++; if (ctl3 !== 5'b00000) begin n_bad++; $display("FAIL br_after: got %b want %b", ctl3, 5'b00000); end
    adv();
  endtask

  task automatic test_freeze_load_stall();
    logic [4:0] ec [8] = '{5'b11100, 5'b11001, 5'b11001, 5'b11001, 5'b11001, 5'b11100, 5'b11100, 5'b00000};
    logic [1:0] es [8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};
    for (int k = 0; k < 8; k++) begin
      if (k == 0)     drv3(1, 6, 6, 1, 0, 0, 0, 0, 1);
      else if (k < 5) drv3(0, 0, 0, 0, 0, 0, 0, 1, 0);
      else            drv3(0, 0, 0, 0, 0, 0, 0, 0, 1);
      settle();
      n_cmp++; if (ctl3 !== ec[k]) begin n_bad++; $display("FAIL frz_ls_ctl[%0d]: got %b want %b", k, ctl3, ec[k]); end
      n_cmp++; if (if3.hazard_state !== es[k]) begin n_bad++; $display("FAIL frz_ls_state[%0d]: got %0d want %0d", k, if3.hazard_state, es[k]); end
      adv();
    end
  endtask

  task automatic test_freeze_exit_branch();
    logic [4:0] ec [4] = '{5'b11001, 5'b11001, 5'b00110, 5'b00000};
    logic [1:0] es [4] = '{2'd0, 2'd2, 2'd2, 2'd0};
    for (int k = 0; k < 4; k++) begin
      if (k < 2)       drv1(0, 0, 0, 0, 0, 0, 1, 1, 0);
      else if (k == 2) drv1(0, 0, 0, 0, 0, 0, 1, 0, 1);
      else             drv1(0, 0, 0, 0, 0, 0, 0, 0, 1);
      settle();
      n_cmp++; if (ctl1 !== ec[k]) begin n_bad++; $display("FAIL frz_br_ctl[%0d]: got %b want %b", k, ctl1, ec[k]); end
      n_cmp++; if (if1.hazard_state !== es[k]) begin n_bad++; $display("FAIL frz_br_state[%0d]: got %0d want %0d", k, if1.hazard_state, es[k]); end
      adv();
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ec [7] = '{5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b00000};
    logic [1:0] es [7] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0};
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drv3(1, 12, 12, 1, 0, 0, 0, 0, 1);
      else       drv3(0, 0, 0, 0, 0, 0, 0, 0, 1);
      settle();
      n_cmp++; if (ctl3 !== ec[k]) begin n_bad++; $display("FAIL b2b_ctl[%0d]: got %b want %b", k, ctl3, ec[k]); end
      n_cmp++; if (if3.hazard_state !== es[k]) begin n_bad++; $display("FAIL b2b_state[%0d]: got %0d want %0d", k, if3.hazard_state, es[k]); end
      adv();
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 5; k++) begin
      drv1(0, 0, 0, 0, 0, 0, 0, 1, 0);
      adv();
    end
    drv1(0, 0, 0, 0, 0, 0, 0, 0, 1);
    settle();
    n_cmp++; if (ctl1 !== 5'b00000) begin n_bad++; $display("FAIL to_gap_ctl: got %b want %b", ctl1, 5'b00000); end
    adv();
    for (int k = 1; k <= 10; k++) begin
      drv1(0, 0, 0, 0, 0, 0, 0, 1, 0);
      settle();
      n_cmp++; if (if1.mem_timeout !== (k >= 9)) begin n_bad++; $display("FAIL to_flag[%0d]: got %b want %b", k, if1.mem_timeout, (k >= 9)); end
      n_cmp++; if (ctl1 !== 5'b11001) begin n_bad++; $display("FAIL to_freeze[%0d]: got %b want %b", k, ctl1, 5'b11001); end
      adv();
    end
    drv1(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      settle();
      n_cmp++; if (if1.mem_timeout !== 1'b1) begin n_bad++; $display("FAIL to_sticky[%0d]: got %b want 1", k, if1.mem_timeout); end
      n_cmp++; if (ctl1 !== 5'b00000) begin n_bad++; $display("FAIL to_resume[%0d]: got %b want %b", k, ctl1, 5'b00000); end
      adv();
    end
    reset = 1'b1;
    settle();
    n_cmp++; if (if1.mem_timeout !== 1'b0) begin n_bad++; $display("FAIL to_in_reset: got %b want 0", if1.mem_timeout); end
    adv();
    reset = 1'b0;
    settle();
    n_cmp++; if (if1.mem_timeout !== 1'b0) begin n_bad++; $display("FAIL to_cleared: got %b want 0", if1.mem_timeout); end
    adv();
  endtask

  task automatic test_perf();
    reset = 1'b1;
    adv();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drv1(1, 3, 0, 0, 3, 1, 0, 0, 1);
      adv();
      drv1(0, 0, 0, 0, 0, 0, 0, 0, 1);
      adv();
    end
    for (int k = 0; k < 2; k++) begin
      drv1(0, 0, 0, 0, 0, 0, 1, 0, 1);
      adv();
      drv1(0, 0, 0, 0, 0, 0, 0, 0, 1);
      adv();
    end
    settle();
    n_cmp++; if (if1.stall_cycles !== (PERF ? 32'd3 : 32'd0)) begin n_bad++; $display("FAIL perf_stall: got %0d want %0d", if1.stall_cycles, (PERF ? 3 : 0)); end
    n_cmp++; if (if1.flush_count !== (PERF ? 32'd2 : 32'd0)) begin n_bad++; $display("FAIL perf_flush: got %0d want %0d", if1.flush_count, (PERF ? 2 : 0)); end
    adv();
    drv1(0, 0, 0, 0, 0, 0, 0, 1, 0);
    adv();
    settle();
    n_cmp++; if (if1.stall_cycles !== (PERF ? 32'd4 : 32'd0)) begin n_bad++; $display("FAIL perf_freeze_stall: got %0d want %0d", if1.stall_cycles, (PERF ? 4 : 0)); end
    reset = 1'b1;
    #1;
    n_cmp++; if (if1.stall_cycles !== 32'd0) begin n_bad++; $display("FAIL perf_in_reset: got %0d want 0", if1.stall_cycles); end
    n_cmp++; if (ctl1 !== 5'b00000) begin n_bad++; $display("FAIL perf_rst_ctl: got %b want %b", ctl1, 5'b00000); end
    adv();
    reset = 1'b0;
    drv1(0, 0, 0, 0, 0, 0, 0, 0, 1);
    settle();
    n_cmp++; if (if1.stall_cycles !== 32'd0 || if1.flush_count !== 32'd0) begin n_bad++; $display("FAIL perf_cleared: got %0d/%0d want 0/0", if1.stall_cycles, if1.flush_count); end
    n_cmp++; if (if1.hazard_state !== 2'd0) begin n_bad++; $display("FAIL perf_rst_state: got %0d want 0", if1.hazard_state); end
    adv();
  endtask

  task automatic test_reset_mid_stall();
    drv3(1, 8, 8, 1, 0, 0, 0, 0, 1);
    adv();
    drv3(0, 0, 0, 0, 0, 0, 0, 1, 0);
    settle();
    n_cmp++; if (if3.hazard_state !== 2'd1) begin n_bad++; $display("FAIL rms_pre_state: got %0d want 1", if3.hazard_state); end
    adv();
    reset = 1'b1;
    settle();
    n_cmp++; if (ctl3 !== 5'b00000) begin n_bad++; $display("FAIL rms_in_reset: got %b want %b", ctl3, 5'b00000); end
    adv();
    reset = 1'b0;
    drv3(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      settle();
      n_cmp++; if (ctl3 !== 5'b00000) begin n_bad++; $display("FAIL rms_ctl[%0d]: got %b want %b", k, ctl3, 5'b00000); end
      n_cmp++; if (if3.hazard_state !== 2'd0) begin n_bad++; $display("FAIL rms_state[%0d]: got %0d want 0", k, if3.hazard_state); end
      adv();
    end
  endtask

  initial begin
    drv1(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drv3(0, 0, 0, 0, 0, 0, 0, 0, 1);
    adv();
    adv();
    test_reset();
    test_load_use_single();
    test_load_use_multi();
    test_branch_priority();
    test_freeze_load_stall();
    test_freeze_exit_branch();
    test_back_to_back();
    test_timeout();
    test_perf();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_hazard_unit.md
# cpu_hazard_unit

Pipeline hazard control for the 5-stage core; the partner of the forwarding unit. It covers the cases forwarding cannot resolve:
- load-use dependencies, handled by stalling IF/ID and injecting bubbles into ID/EX;
- taken branches resolved in EX, handled by flushing the wrong path;
- data-memory wait states in MEM, handled by freezing the whole pipeline.

After a load-use stall, the forwarding unit supplies the load data from the WB stage.

## Interface
Parameters:
- REG_ADDR_W, 5: register index width.
- LOAD_USE_BUBBLES, 1: bubbles inserted per load-use hazard. Legal values are 1 to 3.
- MEM_TIMEOUT, 256: consecutive memory-wait cycles before mem_timeout is raised. Must be at least 2.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- ra_id, rb_id  in  REG_ADDR_W  source registers of the instruction in ID.
- ra_used_id, rb_used_id  in  1  source register actually read.
- rd_ex  in  REG_ADDR_W  destination register of the instruction in EX.
- memread_ex  in  1  instruction in EX is a load.
- branch_taken_ex  in  1  redirect resolved in EX.
- dmem_req_mem, dmem_ready_mem  in  1  data-memory request and ready in MEM.
- stall_if  out  1  hold the PC.
- stall_id  out  1  hold the IF/ID register.
- bubble_ex  out  1  load a NOP into ID/EX.
- flush_if_id  out  1  clear IF/ID.
- freeze_pipe  out  1  hold ID/EX, EX/MEM and MEM/WB.
- mem_timeout  out  1  sticky memory-timeout error.
- hazard_state  out  2  current FSM state.
- stall_cycles, flush_count  out  32  performance counters (see Configuration).

## Operation
Definitions:
- mem_wait = dmem_req_mem & ~dmem_ready_mem.
- load_use = memread_ex & (rd_ex != 0) & ((ra_used_id & ra_id == rd_ex) | (rb_used_id & rb_id == rd_ex)).

FSM states: RUN=0, LOAD_STALL=1, MEM_WAIT=2. Registers: bubble counter bcnt (2 bits), return state ret, timeout counter tcnt.

Output priority is evaluated every cycle:
1. mem_wait, from any state: freeze_pipe=stall_if=stall_id=1; bubble_ex=flush_if_id=0. If the state is not MEM_WAIT, save the current state in ret and move to MEM_WAIT. bcnt holds.
2. State LOAD_STALL: stall_if=stall_id=bubble_ex=1. bcnt decrements; when bcnt==1, return to RUN.
3. branch_taken_ex in RUN: flush_if_id=bubble_ex=1, no stall. The branch has priority over load-use because the ID instruction is squashed.
4. load_use in RUN: stall_if=stall_id=bubble_ex=1. If LOAD_USE_BUBBLES>1, go to LOAD_STALL with bcnt=LOAD_USE_BUBBLES-1; otherwise stay in RUN.
5. Otherwise all control outputs are 0.

MEM_WAIT exit:
- On the first cycle with mem_wait=0, return to ret, and that cycle is evaluated as state ret.
- A branch or load held in EX during the freeze is therefore handled on the exit cycle.

Timeout:
- tcnt counts consecutive mem_wait cycles and saturates at MEM_TIMEOUT.
- mem_timeout sets when tcnt reaches MEM_TIMEOUT and stays set until reset.
- The freeze is not aborted.
- tcnt clears on any cycle with mem_wait=0.

branch_taken_ex in LOAD_STALL cannot occur because EX holds a bubble. The bench asserts that it never happens.

## Timing
- All control outputs are combinational from the current state and inputs, in the same cycle (zero latency). State and counters update on the clock edge.
- Reset:
  - While reset=1, all outputs are 0.
  - After reset, state=RUN and bcnt=tcnt=0; mem_timeout, stall_cycles and flush_count are 0.
  - Reset mid-stall or mid-freeze drops to RUN on the next edge; the pending stall is discarded.
- A load-use hazard produces exactly LOAD_USE_BUBBLES stall cycles, not counting freeze cycles.
- A taken branch produces exactly 1 flush cycle.
- Back-to-back loads: the second hazard is detected only once the first load's bubbles have drained.

## Configuration
CPU_HAZARD_PERF_EN:
- Defined:
  - stall_cycles increments on every cycle with stall_if=1.
  - flush_count increments on every cycle with flush_if_id=1.
  - Both are 32-bit, wrap modulo 2^32, and clear on reset.
- Undefined: both ports remain and are tied to 0, and no counter logic is generated.

## Structure
- Shared package cpu_hazard_pkg:
  - hazard_state_t enum (RUN, LOAD_STALL, MEM_WAIT);
  - REG_ADDR_W default;
  - PERF_CNT_W=32.
- One sub-module, cpu_hazard_perf_counters, holds both counters and is instantiated only under CPU_HAZARD_PERF_EN.

## Test plan
- Load-use: memread_ex=1, rd_ex=5, ra_id=5, ra_used_id=1, LOAD_USE_BUBBLES=1 -> exactly 1 cycle with stall_if=stall_id=bubble_ex=1, then all outputs 0.
  - Same stimulus with rd_ex=0, or with ra_used_id=0 -> no stall.
- LOAD_USE_BUBBLES=3, hazard on rb -> 3 consecutive stall cycles; hazard_state shows 1 for 2 cycles.
- Branch and load-use in the same cycle -> flush_if_id=bubble_ex=1, stall_if=0, state stays RUN.
- dmem_req_mem=1, dmem_ready_mem=0 for 4 cycles during LOAD_STALL (bcnt=2) -> freeze_pipe=1 for 4 cycles, state 2, then resume LOAD_STALL with bcnt=2 and finish the remaining 2 stall cycles.
- MEM_TIMEOUT=8, memory held not-ready for 10 cycles -> mem_timeout rises after the 8th cycle and stays 1 after ready; cleared only by reset.
- With CPU_HAZARD_PERF_EN: 3 load-use stalls plus 2 branches -> stall_cycles=3, flush_count=2.
  - Reset mid-freeze -> counters 0, state RUN.
